// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared types and constants for the memory-port arbiter.
//                Holds the arbiter FSM encoding and the default error word
//                returned when the device never answers.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  // Arbiter FSM states: pick a requester, present it to the device, await reply.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  // Data word handed back to a requester whose access timed out.
  localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEAD_BEEF;

  // Width of a requester index; never narrower than one bit.
  function automatic int idx_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_port_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
//  Module      : rr_picker
//  Description : Combinational round-robin selector. Returns the first set
//                request bit found searching upward from ptr, wrapping at
//                NUM_REQ, plus a flag saying whether any request is set.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_picker
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               any_req,
  output logic [IDX_W-1:0]   pick_idx
);

  // Walk offsets from the farthest to the nearest so the candidate closest
  // to ptr is the one left standing at the end of the loop.
  always_comb begin
    any_req  = 1'b0;
    pick_idx = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      int j;
      j = int'(ptr) + off;
      if (j >= NUM_REQ) begin
        j = j - NUM_REQ;
      end
      if (req[j]) begin
        any_req  = 1'b1;
        pick_idx = j[IDX_W-1:0];
      end
    end
  end

endmodule : rr_picker
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Round-robin arbiter sharing one MemPort-style slave among
//                NUM_REQ masters. One transaction in flight at a time; the
//                grant is held from issue until the device responds or a
//                response timeout forces an error reply.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int                   NUM_REQ  = 2,
  parameter int                   ADDR_W   = 32,
  parameter int                   DATA_W   = 32,
  parameter int                   TIMEOUT  = 255,
  parameter logic [DATA_W-1:0]    ERR_DATA = DATA_W'(DEFAULT_ERR_DATA)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_write_en,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_REQ-1:0]          req_rvalid,
  output logic [DATA_W-1:0]           req_rdata,
  output logic                        dev_valid,
  output logic                        dev_write_en,
  output logic [ADDR_W-1:0]           dev_addr,
  output logic [DATA_W-1:0]           dev_wdata,
  input  logic                        dev_ready,
  input  logic                        dev_rvalid,
  input  logic [DATA_W-1:0]           dev_rdata,
  output logic [idx_width(NUM_REQ)-1:0] grant_idx,
  output logic                        timeout_err
);

  localparam int                 IDX_W       = idx_width(NUM_REQ);
  localparam int                 CNT_W       = 16;
  localparam logic [CNT_W-1:0]   TIMEOUT_CNT = CNT_W'(TIMEOUT);
  localparam logic [IDX_W-1:0]   LAST_IDX    = IDX_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0    = NUM_REQ'(1);

  arb_state_e         state_q,     state_d;
  logic [IDX_W-1:0]   rr_ptr_q,    rr_ptr_d;
  logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;

  logic [ADDR_W-1:0]  w_addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]  w_wdata_arr [NUM_REQ];

  logic               w_any_req;
  logic [IDX_W-1:0]   w_pick_idx;
  logic               w_in_issue;
  logic               w_in_wait;
  logic               w_gnt_valid;
  logic               w_accept;
  logic               w_resp_dev;
  logic               w_resp_tmo;
  logic [NUM_REQ-1:0] w_gnt_onehot;

  // Split the packed request buses into per-requester words for muxing.
  generate
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign w_addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
      assign w_wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
    end
  endgenerate

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req      (req_valid),
    .ptr      (rr_ptr_q),
    .any_req  (w_any_req),
    .pick_idx (w_pick_idx)
  );

  // Per-cycle qualifiers derived from the current state and granted port.
  always_comb begin
    w_in_issue   = (state_q == ISSUE);
    w_in_wait    = (state_q == WAIT);
    w_gnt_valid  = req_valid[grant_idx_q];
    w_accept     = w_in_issue & w_gnt_valid & dev_ready;
    w_resp_dev   = w_in_wait & dev_rvalid;
    // A real response arriving on the timeout cycle takes precedence.
    w_resp_tmo   = w_in_wait & ~dev_rvalid & (cnt_q == TIMEOUT_CNT);
    w_gnt_onehot = ONE_HOT0 << grant_idx_q;
  end

  // Next-state, round-robin pointer, grant and timeout counter.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_idx_d = grant_idx_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (w_any_req) begin
          grant_idx_d = w_pick_idx;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (w_accept) begin
          state_d = WAIT;
          cnt_d   = '0;
        end else if (!w_gnt_valid) begin
          // Requester withdrew before acceptance: re-arbitrate without
          // moving the pointer so it keeps its priority.
          state_d = IDLE;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (w_resp_dev || w_resp_tmo) begin
          rr_ptr_d = (grant_idx_q == LAST_IDX) ? '0 : grant_idx_q + 1'b1;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_idx_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_idx_q <= grant_idx_d;
      cnt_q       <= cnt_d;
    end
  end

  // Device-side request mirrors the granted requester only while issuing.
  always_comb begin
    dev_valid    = w_in_issue & w_gnt_valid;
    dev_write_en = w_in_issue & req_write_en[grant_idx_q];
    dev_addr     = w_in_issue ? w_addr_arr[grant_idx_q]  : '0;
    dev_wdata    = w_in_issue ? w_wdata_arr[grant_idx_q] : '0;
  end

  // Requester-side strobes and response data routing.
  always_comb begin
    req_ready   = w_accept ? w_gnt_onehot : '0;
    req_rvalid  = (w_resp_dev | w_resp_tmo) ? w_gnt_onehot : '0;
    req_rdata   = w_resp_dev ? dev_rdata : (w_resp_tmo ? ERR_DATA : '0);
    timeout_err = w_resp_tmo;
    grant_idx   = grant_idx_q;
  end

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Directed self-checking bench for mem_port_arbiter with two
//                requesters and a short response timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 4;

  logic                      clk;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_write_en;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_rvalid;
  logic [DATA_W-1:0]         req_rdata;
  logic                      dev_valid;
  logic                      dev_write_en;
  logic [ADDR_W-1:0]         dev_addr;
  logic [DATA_W-1:0]         dev_wdata;
  logic                      dev_ready;
  logic                      dev_rvalid;
  logic [DATA_W-1:0]         dev_rdata;
  logic [0:0]                grant_idx;
  logic                      timeout_err;

  int n_total = 0;
  int n_bad   = 0;

  mem_port_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_write_en (req_write_en),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_ready    (req_ready),
    .req_rvalid   (req_rvalid),
    .req_rdata    (req_rdata),
    .dev_valid    (dev_valid),
    .dev_write_en (dev_write_en),
    .dev_addr     (dev_addr),
    .dev_wdata    (dev_wdata),
    .dev_ready    (dev_ready),
    .dev_rvalid   (dev_rvalid),
    .dev_rdata    (dev_rdata),
    .grant_idx    (grant_idx),
    .timeout_err  (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Full read transaction with a same-cycle-ready, next-cycle-rvalid device.
  task automatic txn(input logic [1:0] vld, input int exp_g, input logic [31:0] rdat);
    req_valid  = vld;
    dev_ready  = 1'b1;
    dev_rvalid = 1'b0;
    #1;
    chk("idle_ready", 64'(req_ready), 64'd0);
    chk("idle_dev_valid", 64'(dev_valid), 64'd0);
    cyc();
    #1;
    chk("issue_grant", 64'(grant_idx), 64'(exp_g));
    chk("issue_ready", 64'(req_ready), 64'(1 << exp_g));
    chk("issue_rvalid", 64'(req_rvalid), 64'd0);
    cyc();
    dev_rvalid = 1'b1;
    dev_rdata  = rdat;
    #1;
    chk("wait_rvalid", 64'(req_rvalid), 64'(1 << exp_g));
    chk("wait_rdata", 64'(req_rdata), 64'(rdat));
    chk("wait_ready", 64'(req_ready), 64'd0);
    cyc();
    dev_rvalid = 1'b0;
  endtask

  initial begin
    rst          = 1'b0;
    req_valid    = '0;
    req_write_en = '0;
    req_addr     = '0;
    req_wdata    = '0;
    dev_ready    = 1'b0;
    dev_rvalid   = 1'b0;
    dev_rdata    = '0;

    // Reset state, with inputs active to show they are masked.
    cyc();
    req_valid  = 2'b11;
    dev_ready  = 1'b1;
    dev_rvalid = 1'b1;
    dev_rdata  = 32'h1111_2222;
    cyc();
    #1;
    chk("rst_dev_valid", 64'(dev_valid), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_req_rvalid", 64'(req_rvalid), 64'd0);
    chk("rst_req_rdata", 64'(req_rdata), 64'd0);
    chk("rst_grant", 64'(grant_idx), 64'd0);
    chk("rst_timeout", 64'(timeout_err), 64'd0);
    req_valid  = '0;
    dev_ready  = 1'b0;
    dev_rvalid = 1'b0;
    dev_rdata  = '0;
    rst        = 1'b1;
    cyc();

    // Single read from requester 1 at 0x10.
    req_valid = 2'b10;
    req_addr  = {32'h0000_0010, 32'h0000_0020};
    dev_ready = 1'b1;
    #1;
    chk("rd1_c0_ready", 64'(req_ready), 64'd0);
    chk("rd1_c0_dev_valid", 64'(dev_valid), 64'd0);
    cyc();
    #1;
    chk("rd1_c1_ready", 64'(req_ready), 64'b10);
    chk("rd1_c1_dev_valid", 64'(dev_valid), 64'd1);
    chk("rd1_c1_addr", 64'(dev_addr), 64'h10);
    chk("rd1_c1_we", 64'(dev_write_en), 64'd0);
    chk("rd1_c1_grant", 64'(grant_idx), 64'd1);
    cyc();
    req_valid  = 2'b00;
    dev_rvalid = 1'b1;
    dev_rdata  = 32'h5A;
    #1;
    chk("rd1_c2_rvalid", 64'(req_rvalid), 64'b10);
    chk("rd1_c2_rdata", 64'(req_rdata), 64'h5A);
    chk("rd1_c2_dev_valid", 64'(dev_valid), 64'd0);
    cyc();
    dev_rvalid = 1'b0;
    #1;
    chk("rd1_c3_rvalid", 64'(req_rvalid), 64'd0);
    chk("rd1_c3_rdata", 64'(req_rdata), 64'd0);

    // Round robin with both requesting continuously: 0,1,0,1.
    for (int k = 0; k < 4; k++) begin
      txn(2'b11, k % 2, 32'h100 + 32'(k));
    end

    // Stray dev_rvalid while idle produces nothing.
    req_valid  = 2'b00;
    dev_rvalid = 1'b1;
    dev_rdata  = 32'hBAD0;
    #1;
    chk("stray_rvalid", 64'(req_rvalid), 64'd0);
    chk("stray_rdata", 64'(req_rdata), 64'd0);
    cyc();
    dev_rvalid = 1'b0;
    #1;
    chk("stray_dev_valid", 64'(dev_valid), 64'd0);

    // Timeout on a write from requester 0.
    req_valid    = 2'b01;
    req_write_en = 2'b01;
    req_wdata    = {32'h0, 32'h0000_CAFE};
    dev_ready    = 1'b1;
    cyc();
    #1;
    chk("tmo_we", 64'(dev_write_en), 64'd1);
    chk("tmo_wdata", 64'(dev_wdata), 64'hCAFE);
    cyc();
    for (int w = 0; w < TIMEOUT; w++) begin
      #1;
      chk("tmo_early_rvalid", 64'(req_rvalid), 64'd0);
      chk("tmo_early_err", 64'(timeout_err), 64'd0);
      cyc();
    end
    #1;
    chk("tmo_rvalid", 64'(req_rvalid), 64'b01);
    chk("tmo_err", 64'(timeout_err), 64'd1);
    chk("tmo_rdata", 64'(req_rdata), 64'hDEAD_BEEF);
    cyc();
    req_write_en = 2'b00;
    #1;
    chk("tmo_err_clear", 64'(timeout_err), 64'd0);
    txn(2'b01, 0, 32'h1234);

    // dev_rvalid on the timeout cycle wins.
    req_valid = 2'b01;
    dev_ready = 1'b1;
    cyc();
    cyc();
    for (int w = 0; w < TIMEOUT; w++) begin
      cyc();
    end
    dev_rvalid = 1'b1;
    dev_rdata  = 32'h77;
    #1;
    chk("coin_rvalid", 64'(req_rvalid), 64'b01);
    chk("coin_rdata", 64'(req_rdata), 64'h77);
    chk("coin_err", 64'(timeout_err), 64'd0);
    cyc();
    dev_rvalid = 1'b0;
    txn(2'b10, 1, 32'h55);

    // Requester 0 withdraws during a stalled issue and keeps priority.
    req_valid = 2'b01;
    dev_ready = 1'b0;
    #1;
    chk("wd_idle_dev_valid", 64'(dev_valid), 64'd0);
    cyc();
    #1;
    chk("wd_issue_dev_valid", 64'(dev_valid), 64'd1);
    chk("wd_issue_ready", 64'(req_ready), 64'd0);
    chk("wd_issue_grant", 64'(grant_idx), 64'd0);
    cyc();
    req_valid = 2'b00;
    #1;
    chk("wd_drop_dev_valid", 64'(dev_valid), 64'd0);
    chk("wd_drop_ready", 64'(req_ready), 64'd0);
    cyc();
    #1;
    chk("wd_back_idle", 64'(dev_valid), 64'd0);
    txn(2'b11, 0, 32'h66);

    // Asynchronous reset in the middle of a response cycle.
    req_valid = 2'b10;
    dev_ready = 1'b1;
    cyc();
    cyc();
    dev_rvalid = 1'b1;
    dev_rdata  = 32'h99;
    #1;
    chk("mrst_pre_rvalid", 64'(req_rvalid), 64'b10);
    rst = 1'b0;
    #1;
    chk("mrst_rvalid", 64'(req_rvalid), 64'd0);
    chk("mrst_rdata", 64'(req_rdata), 64'd0);
    chk("mrst_grant", 64'(grant_idx), 64'd0);
    chk("mrst_dev_valid", 64'(dev_valid), 64'd0);
    #2;
    rst        = 1'b1;
    dev_rvalid = 1'b0;
    req_valid  = 2'b11;
    #1;
    chk("mrst_idle", 64'(dev_valid), 64'd0);
    cyc();
    #1;
    chk("mrst_ptr_grant", 64'(grant_idx), 64'd0);
    chk("mrst_ptr_ready", 64'(req_ready), 64'b01);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Safety net against a stalled run.
  initial begin
    #20000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

endmodule : tb_mem_port_arbiter
`default_nettype wire
